pow2_mod_seq: RTL and testbench

//  Sequential generator of CRT/RNS weights 2^n mod m for a runtime modulus m and exponent n.
//  - Computes by repeated modular doubling; no per-modulus tables.
//  - Sits between the RNS modulus configuration and the CRT reconstruction datapath.
//  - Uses valid/ready handshakes on both the request side and the result side.

---
 rtl/pow2_mod_seq.sv | 104 ++++++++++
 tb/tb_pow2_mod_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pow2_mod_seq.sv
// Sequential 2^n mod m generator for CRT/RNS weights, built from repeated modular doubling.
// Valid/ready handshakes on both the request and result sides, with one job in flight at a time.
module pow2_mod_seq #(
  parameter int unsigned MOD_W = 16,
  parameter int unsigned EXP_W = 5,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MOD_W-1:0] m,
  input  logic [EXP_W-1:0] n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [MOD_W-1:0] r;
  logic [MOD_W-1:0] m_q;
  logic [EXP_W-1:0] cnt;
  logic             err_q;
  logic             accept;
  logic [MOD_W-1:0] r_shl;
  logic             dbl_ge;
  logic [MOD_W-1:0] r_dbl;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && (state == IDLE) && !clr;
  assign result    = OUT_W'(r);
  assign err       = err_q;

  // 2r >= m evaluated at MOD_W+1 bits: the dropped carry of 2r is r's MSB.
  // When it is set the true difference is still < m, so the MOD_W-bit wrap is exact.
  always_comb begin
    r_shl  = {r[MOD_W-2:0], 1'b0};
    dbl_ge = r[MOD_W-1] || (r_shl >= m_q);
    r_dbl  = dbl_ge ? (r_shl - m_q) : r_shl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = ((m == '0) || (n == '0)) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == EXP_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r     <= '0;
      m_q   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (clr) begin
      r     <= r;
    end else if (accept) begin
      m_q   <= m;
      cnt   <= n;
      err_q <= (m == '0);
      r     <= (m > MOD_W'(1)) ? MOD_W'(1) : '0;
    end else if (state == RUN) begin
      r     <= r_dbl;
      cnt   <= cnt - EXP_W'(1);
    end
  end

endmodule

// File: tb/tb_pow2_mod_seq.sv
// Directed self-checking bench for pow2_mod_seq with hand-computed 2^n mod m values.
// Latency is counted in rising edges, with the accepting edge counted as edge 1.
module tb_pow2_mod_seq;

  localparam int unsigned MOD_W = 16;
  localparam int unsigned EXP_W = 5;
  localparam int unsigned OUT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [MOD_W-1:0] m;
  logic [EXP_W-1:0] n;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] result;
  logic             err;

  int n_cmp = 0;
  int n_mis = 0;

  pow2_mod_seq #(.MOD_W(MOD_W), .EXP_W(EXP_W), .OUT_W(OUT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .m        (m),
    .n        (n),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one request and wait for out_valid; caller is positioned #1 after a rising edge.
  task automatic issue(input logic [MOD_W-1:0] mv, input logic [EXP_W-1:0] nv,
                       output int edges);
    m        = mv;
    n        = nv;
    in_valid = 1'b1;
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    m        = $urandom_range(0, 65535);
    n        = EXP_W'($urandom_range(0, 31));
    edges    = 1;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic run_job(input string tag, input logic [MOD_W-1:0] mv,
                         input logic [EXP_W-1:0] nv, input logic [OUT_W-1:0] exp_res,
                         input logic exp_err, input int exp_lat);
    int edges;
    issue(mv, nv, edges);
    check({tag, "_latency"}, 64'(edges), 64'(exp_lat));
    check({tag, "_result"}, 64'(result), 64'(exp_res));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_idle_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int edges;
    logic [OUT_W-1:0] exp3;
    logic             seen;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    m         = '0;
    n         = '0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 2^n mod 3 alternates 1,2
    for (int i = 0; i < 32; i++) begin
      exp3 = (i % 2 == 0) ? 32'd1 : 32'd2;
      run_job($sformatf("m3_n%0d", i), 16'd3, EXP_W'(i), exp3, 1'b0, i + 1);
    end

    run_job("m7_n5", 16'd7, 5'd5, 32'd4, 1'b0, 6);
    run_job("m65535_n31", 16'd65535, 5'd31, 32'd32768, 1'b0, 32);
    run_job("m1_n9", 16'd1, 5'd9, 32'd0, 1'b0, 10);
    run_job("m0_n4", 16'd0, 5'd4, 32'd0, 1'b1, 1);

    // result held under backpressure
    issue(16'd13, 5'd12, edges);
    check("bp_latency", 64'(edges), 64'd13);
    for (int i = 0; i < 10; i++) begin
      check("bp_result", 64'(result), 64'd1);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);

    // request coincident with clr is ignored
    m        = 16'd7;
    n        = 5'd2;
    in_valid = 1'b1;
    clr      = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
    check("clr_req_not_accepted", 64'(in_ready), 64'd1);

    // clr on the 5th RUN cycle: r sequence 1,2,4,8,5 then frozen
    m        = 16'd11;
    n        = 5'd20;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("clr_in_run", 64'(in_ready), 64'd0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_in_ready", 64'(in_ready), 64'd1);
    check("clr_out_valid", 64'(out_valid), 64'd0);
    check("clr_result_held", 64'(result), 64'd5);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("clr_no_out_valid", 64'(seen), 64'd0);
    run_job("m5_n3", 16'd5, 5'd3, 32'd3, 1'b0, 4);

    // asynchronous reset mid-RUN
    m        = 16'd9;
    n        = 5'd15;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_result", 64'(result), 64'd0);
    check("arst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("arst_no_stale_valid", 64'(seen), 64'd0);
    run_job("m9_n6", 16'd9, 5'd6, 32'd1, 1'b0, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
